// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage behind a 128x8 synchronous ROM. It owns the pc, absorbs the
// one-cycle ROM read latency and issues 1- or 2-byte instructions over a valid/ready handshake.
module instr_fetch_unit (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] address,
  input  logic [7:0] rom_data,
  output logic [7:0] opcode,
  output logic [7:0] operand,
  output logic       has_operand,
  output logic       instr_valid,
  input  logic       instr_ready,
  input  logic       branch_taken,
  input  logic [7:0] branch_target,
  output logic [7:0] pc,
  output logic       fault
);

  localparam logic [7:0] ROM_LAST = 8'h7F;

  localparam logic [7:0] LDA_IMM = 8'h01;
  localparam logic [7:0] LDB_IMM = 8'h02;
  localparam logic [7:0] LDA_DIR = 8'h03;
  localparam logic [7:0] STA_DIR = 8'h04;
  localparam logic [7:0] STR_DIR = 8'h05;
  localparam logic [7:0] BRA     = 8'h06;
  localparam logic [7:0] BEQ     = 8'h07;
  localparam logic [7:0] BMI     = 8'h08;

  typedef enum logic [2:0] {FETCH, DECODE, OPND, ISSUE, FAULT} state_t;
  state_t state;

  logic two_byte;
  always_comb begin
    two_byte = 1'b0;
    case (rom_data)
      LDA_IMM, LDB_IMM, LDA_DIR, STA_DIR,
      STR_DIR, BRA, BEQ, BMI: two_byte = 1'b1;
      default:                two_byte = 1'b0;
    endcase
  end

  assign address = pc;

  // instr_valid and fault are registered alongside the state so neither has a combinational input path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= 8'h00;
      opcode      <= 8'h00;
      operand     <= 8'h00;
      has_operand <= 1'b0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (pc > ROM_LAST) begin
            state <= FAULT;
            fault <= 1'b1;
          end else begin
            pc    <= pc + 8'd1;
            state <= DECODE;
          end
        end
        DECODE: begin
          opcode <= rom_data;
          if (two_byte) begin
            // Opcode sat at the last ROM byte: its operand would lie outside ROM space.
            if (pc > ROM_LAST) begin
              state <= FAULT;
              fault <= 1'b1;
            end else begin
              pc    <= pc + 8'd1;
              state <= OPND;
            end
          end else begin
            operand     <= 8'h00;
            has_operand <= 1'b0;
            instr_valid <= 1'b1;
            state       <= ISSUE;
          end
        end
        OPND: begin
          operand     <= rom_data;
          has_operand <= 1'b1;
          instr_valid <= 1'b1;
          state       <= ISSUE;
        end
        ISSUE: begin
          if (instr_ready) begin
            if (branch_taken) pc <= branch_target;
            instr_valid <= 1'b0;
            state       <= FETCH;
          end
        end
        FAULT: begin
          instr_valid <= 1'b0;
          fault       <= 1'b1;
        end
        default: state <= FAULT;
      endcase
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage sitting directly downstream of the 128x8 synchronous program ROM. It owns the program counter, drives the ROM address, absorbs the ROM's one-cycle registered read latency, and assembles one- or two-byte instructions (opcode plus optional operand) into a single valid/ready hand-off to the control/execute stage. Branch redirects from execute are applied at hand-off; fetches outside ROM space raise a sticky fault.

## Interface
- ROM_LAST, 8'h7F, highest valid program address; any fetch above it faults
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- address  out  8  ROM address; always equal to the internal pc register
- rom_data  in  8  ROM data_out; valid the cycle after address was sampled
- opcode  out  8  captured opcode of the issued instruction
- operand  out  8  captured second byte; 8'h00 for one-byte instructions
- has_operand  out  1  high when the issued instruction is two bytes
- instr_valid  out  1  instruction on opcode/operand is ready for execute
- instr_ready  in  1  execute accepts instruction this cycle
- branch_taken  in  1  sampled only on accept; redirect pc
- branch_target  in  8  new pc when branch_taken on accept
- pc  out  8  current program counter
- fault  out  1  sticky; fetch attempted above ROM_LAST

## Operation
- Two-byte opcodes (`instructions.v` macros): LDA_IMM, LDB_IMM, LDA_DIR, STA_DIR, STR_DIR, BRA, BEQ, BMI. All others are one-byte (e.g. SUB_AB, INCA, DECA).
- States: FETCH, DECODE, OPND, ISSUE, FAULT.
- FETCH: if pc > ROM_LAST -> FAULT; else pc <= pc+1, -> DECODE (ROM samples opcode address this edge).
- DECODE: opcode <= rom_data. Two-byte: pc <= pc+1, -> OPND (ROM samples operand address this edge). One-byte: operand <= 0, has_operand <= 0, -> ISSUE.
- DECODE with two-byte opcode and pc > ROM_LAST (opcode at last ROM byte): -> FAULT, pc unchanged.
- OPND: operand <= rom_data, has_operand <= 1, -> ISSUE.
- ISSUE: instr_valid = 1. Hold opcode/operand/has_operand stable until instr_valid && instr_ready. On accept: if branch_taken pc <= branch_target, else pc unchanged; -> FETCH.
- FAULT: fault = 1, instr_valid = 0, pc frozen; exit only by reset.
- pc arithmetic is 8-bit modulo; 8'hFF+1 = 8'h00 never occurs because FETCH faults first.
- branch_taken/branch_target ignored outside an accept cycle.

## Timing
- Reset values: pc = 8'h00, address = 8'h00, opcode = 8'h00, operand = 8'h00, has_operand = 0, instr_valid = 0, fault = 0, state = FETCH.
- instr_valid is a registered state decode (high exactly in ISSUE); no combinational path from instr_ready to instr_valid.
- Latency, FETCH entry to instr_valid: one-byte 2 cycles, two-byte 3 cycles.
- Accept cycle returns to FETCH next cycle; back-to-back one-byte throughput 1 instr / 3 cycles, two-byte 1 / 4.
- Branch target is on address the cycle after accept; target's opcode captured the cycle after that.
- instr_ready low in ISSUE: stall indefinitely, no pc change, outputs stable.
- Reset asserted in any state: outputs take reset values asynchronously; first FETCH after deassert uses pc = 8'h00.

## Test plan
- Reset, ROM[0..1] = LDA_IMM, 8'h07, instr_ready = 1 -> address 00,01,02; instr_valid in 4th cycle after reset release with opcode LDA_IMM, operand 8'h07, has_operand 1, pc 8'h02.
- ROM[4] = SUB_AB after pc = 4 -> valid 2 cycles after FETCH, operand 8'h00, has_operand 0, pc 8'h05.
- Hold instr_ready = 0 for 10 cycles in ISSUE -> opcode/operand/pc unchanged, instr_valid stays 1, no new ROM address.
- Accept BEQ, 8'h14 with branch_taken = 1, branch_target = 8'h11 -> address 8'h11 next cycle; with branch_taken = 0 -> pc continues at 8'h09.
- Branch to 8'h7F where ROM[7F] = BRA -> DECODE faults, fault = 1, instr_valid never asserts; branch_target = 8'h80 -> fault on next FETCH.
- Assert reset mid-OPND -> all outputs reset in same cycle, fault cleared, refetch from 8'h00.
